instr_mem_loader: RTL and testbench

Parametrised, loadable instruction memory for the RV32IM core. Holds 2^ADDR_WIDTH 32-bit words and is written word-by-word over a streaming load port after reset or on demand. Once running, it serves fetches from the core's byte-addressed PC with a fetch handshake and one-cycle synchronous read latency. It supports stall and flags misaligned or out-of-range fetches; unwritten words read as NOP.

---
 rtl/instr_mem_loader.sv | 130 +++++++++++++
 tb/tb_instr_mem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Loadable instruction memory: streams words in while in LOAD, then serves
// byte-addressed fetches with one-cycle read latency while in RUN.
//
// state  | meaning
// S_LOAD | accepting load beats into mem[ptr]; fetches blocked
// S_RUN  | serving fetches; load port closed
module instr_mem_loader #(
   parameter int          ADDR_WIDTH = 5,
   parameter int          PC_WIDTH   = 32,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic                load_valid,
   input  logic [31:0]         load_data,
   output logic                load_ready,
   input  logic                load_done,
   input  logic                fetch_req,
   input  logic [PC_WIDTH-1:0] fetch_addr,
   output logic                fetch_ready,
   input  logic                stall,
   output logic                ins_valid,
   output logic [31:0]         ins_out,
   output logic                ins_fault,
   output logic                running
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH:0]   ptr;
   logic [DEPTH-1:0]      written;
   logic [31:0]           mem [DEPTH];
   logic                  beat;
   logic                  accept;
   logic                  clear_load;
   logic [ADDR_WIDTH-1:0] widx;
   logic                  misaligned;
   logic                  out_of_range;

   assign widx         = fetch_addr[ADDR_WIDTH+1:2];
   assign misaligned   = |fetch_addr[1:0];
   assign out_of_range = |fetch_addr[PC_WIDTH-1:ADDR_WIDTH+2];
   assign running      = (state == S_RUN);

   always_comb begin
      state_nxt   = state;
      load_ready  = 1'b0;
      fetch_ready = 1'b0;
      clear_load  = 1'b0;
      case (state)
         S_LOAD: begin
            load_ready = (ptr != PTR_FULL);
            if (load_start) begin
               clear_load = 1'b1;
            end else if (load_done) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            fetch_ready = !stall && !load_start;
            if (load_start) begin
               clear_load = 1'b1;
               state_nxt  = S_LOAD;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
      // A restart wins over a beat arriving in the same cycle: the pointer is
      // being rewound, so that beat is dropped rather than written at the old slot.
      beat   = load_valid && load_ready && !clear_load;
      accept = fetch_req && fetch_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_LOAD;
         ptr     <= '0;
         written <= '0;
      end else begin
         state <= state_nxt;
         if (clear_load) begin
            ptr     <= '0;
            written <= '0;
         end else if (beat) begin
            ptr                            <= ptr + 1'b1;
            written[ptr[ADDR_WIDTH-1:0]]   <= 1'b1;
         end
      end
   end

   // Storage carries no reset; the written[] flags gate what is visible.
   always_ff @(posedge clk) begin
      if (beat) begin
         mem[ptr[ADDR_WIDTH-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins_valid <= 1'b0;
         ins_out   <= NOP_WORD;
         ins_fault <= 1'b0;
      end else if (state_nxt == S_LOAD) begin
         ins_valid <= 1'b0;
      end else if (accept) begin
         ins_valid <= 1'b1;
         if (misaligned || out_of_range) begin
            ins_out   <= NOP_WORD;
            ins_fault <= 1'b1;
         end else if (!written[widx]) begin
            ins_out   <= NOP_WORD;
            ins_fault <= 1'b0;
         end else begin
            ins_out   <= mem[widx];
            ins_fault <= 1'b0;
         end
      end else if (!stall) begin
         ins_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of fetch vectors plus
// hand-written sequences for stall, reload, full load and async reset.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        stall;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic        ins_fault;
   logic        running;

   instr_mem_loader #(
      .ADDR_WIDTH (5),
      .PC_WIDTH   (32),
      .NOP_WORD   (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .stall       (stall),
      .ins_valid   (ins_valid),
      .ins_out     (ins_out),
      .ins_fault   (ins_fault),
      .running     (running)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_out;
      logic        exp_fault;
   } fvec_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fvec_t       tbl [10];
   logic [31:0] prog [5];
   int          checks = 0;
   int          errors = 0;
   int          beats;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] exp_out,
                            input logic exp_fault, input string name);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      step();
      chk({name, "_valid"}, {31'd0, ins_valid}, 32'd1);
      chk({name, "_out"},   ins_out, exp_out);
      chk({name, "_fault"}, {31'd0, ins_fault}, {31'd0, exp_fault});
      fetch_req = 1'b0;
   endtask

   initial begin
      prog[0] = 32'h3e800093;
      prog[1] = 32'h7d008113;
      prog[2] = 32'hc1810193;
      prog[3] = 32'h83018213;
      prog[4] = 32'h3e820293;

      tbl[0] = '{32'h0000_0000, 32'h3e800093, 1'b0};
      tbl[1] = '{32'h0000_0004, 32'h7d008113, 1'b0};
      tbl[2] = '{32'h0000_0008, 32'hc1810193, 1'b0};
      tbl[3] = '{32'h0000_000C, 32'h83018213, 1'b0};
      tbl[4] = '{32'h0000_0010, 32'h3e820293, 1'b0};
      tbl[5] = '{32'h0000_0014, NOP,          1'b0};
      tbl[6] = '{32'h0000_0080, NOP,          1'b1};
      tbl[7] = '{32'h0000_0006, NOP,          1'b1};
      tbl[8] = '{32'h0000_007C, NOP,          1'b0};
      tbl[9] = '{32'hFFFF_FFFC, NOP,          1'b1};

      rst        = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      load_done  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      stall      = 1'b0;

      #3;
      chk("rst_load_ready",  {31'd0, load_ready},  32'd1);
      chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      chk("rst_running",     {31'd0, running},     32'd0);
      chk("rst_ins_valid",   {31'd0, ins_valid},   32'd0);
      chk("rst_ins_out",     ins_out,              NOP);
      chk("rst_ins_fault",   {31'd0, ins_fault},   32'd0);

      step();
      rst = 1'b0;

      // Five beats; the last one arrives together with load_done.
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_done  = (i == 4);
         #1;
         chk("load_ready_beat", {31'd0, load_ready}, 32'd1);
         step();
      end
      load_valid = 1'b0;
      load_done  = 1'b0;
      #1;
      chk("run_running",     {31'd0, running},     32'd1);
      chk("run_fetch_ready", {31'd0, fetch_ready}, 32'd1);
      chk("run_load_ready",  {31'd0, load_ready},  32'd0);

      // Back-to-back fetches, one result per cycle.
      for (int i = 0; i < 10; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = tbl[i].addr;
         step();
         chk("tbl_valid", {31'd0, ins_valid}, 32'd1);
         chk("tbl_out",   ins_out, tbl[i].exp_out);
         chk("tbl_fault", {31'd0, ins_fault}, {31'd0, tbl[i].exp_fault});
      end
      fetch_req = 1'b0;
      step();
      chk("idle_valid", {31'd0, ins_valid}, 32'd0);
      chk("idle_out",   ins_out, NOP);
      chk("idle_fault", {31'd0, ins_fault}, 32'd1);

      // Stall holds a result while fetch_req stays high.
      fetch_one(32'h4, 32'h7d008113, 1'b0, "pre_stall");
      fetch_req  = 1'b1;
      fetch_addr = 32'h8;
      stall      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_fetch_ready", {31'd0, fetch_ready}, 32'd0);
         step();
         chk("stall_valid", {31'd0, ins_valid}, 32'd1);
         chk("stall_out",   ins_out, 32'h7d008113);
         chk("stall_fault", {31'd0, ins_fault}, 32'd0);
      end
      stall     = 1'b0;
      fetch_req = 1'b0;
      step();
      chk("unstall_valid", {31'd0, ins_valid}, 32'd0);

      // load_start beats a concurrent fetch and clears written[].
      fetch_one(32'h0, 32'h3e800093, 1'b0, "pre_reload");
      load_start = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      #1;
      chk("ls_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      step();
      chk("ls_valid",   {31'd0, ins_valid}, 32'd0);
      chk("ls_running", {31'd0, running},   32'd0);
      load_start = 1'b0;
      fetch_req  = 1'b0;
      load_done  = 1'b1;
      step();
      load_done = 1'b0;
      chk("ls_back_running", {31'd0, running}, 32'd1);
      fetch_one(32'h0, NOP, 1'b0, "empty_fetch");

      // Full load: 34 cycles of load_valid, only 32 beats land.
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("full_running", {31'd0, running}, 32'd0);
      beats      = 0;
      load_valid = 1'b1;
      for (int i = 0; i < 34; i++) begin
         load_data = 32'h1000_0000 + i;
         #1;
         if (load_ready) beats++;
         step();
      end
      chk("full_beats",      beats, 32);
      chk("full_load_ready", {31'd0, load_ready}, 32'd0);
      load_valid = 1'b0;
      load_done  = 1'b1;
      step();
      load_done = 1'b0;
      fetch_one(32'h7C, 32'h1000_001F, 1'b0, "full_last");
      fetch_one(32'h0,  32'h1000_0000, 1'b0, "full_first");
      fetch_one(32'h40, 32'h1000_0010, 1'b0, "full_mid");

      // Async reset after two beats of a reload.
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'hAAAA_0000;
      step();
      load_data  = 32'hAAAA_0001;
      step();
      load_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_load_ready",  {31'd0, load_ready},  32'd1);
      chk("arst_running",     {31'd0, running},     32'd0);
      chk("arst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
      chk("arst_valid",       {31'd0, ins_valid},   32'd0);
      chk("arst_out",         ins_out,              NOP);
      step();
      rst        = 1'b0;
      load_valid = 1'b1;
      load_data  = 32'h0000_0055;
      load_done  = 1'b1;
      step();
      load_valid = 1'b0;
      load_done  = 1'b0;
      fetch_one(32'h0,  32'h0000_0055, 1'b0, "post_rst_w0");
      fetch_one(32'h4,  NOP,           1'b0, "post_rst_w1");
      fetch_one(32'h7C, NOP,           1'b0, "post_rst_w31");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
